// File: rtl/quick_node_pq_pkg.sv
// quickq_pkg: shared types and constants for the QuickQ systolic priority queue.
//   node_state_e : per-node issue FSM (IDLE accepts, WAIT spaces out propagating ops)
//   op_e         : decoded left-side request
//   KEY_W_DEF    : default key width
//   MODE_MIN/MAX : values for the MAX_MODE parameter
package quickq_pkg;

  typedef enum logic [0:0] {IDLE, WAIT} node_state_e;

  typedef enum logic [1:0] {OP_NONE, OP_INSERT, OP_POP, OP_REPLACE} op_e;

  localparam int unsigned KEY_W_DEF = 16;
  localparam int unsigned MODE_MIN  = 0;
  localparam int unsigned MODE_MAX  = 1;

  // write+read together is a replace (pop the head, insert the new key).
  function automatic op_e decode_op(input logic wr, input logic rd);
    op_e op;
    if (wr && rd) begin
      op = OP_REPLACE;
    end else if (wr) begin
      op = OP_INSERT;
    end else if (rd) begin
      op = OP_POP;
    end else begin
      op = OP_NONE;
    end
    return op;
  endfunction

endpackage

// File: rtl/quick_node_pq_key_cmp.sv
// key_cmp: strict priority compare between two keys.
//   a, b     : keys to compare
//   a_better : a strictly beats b (a<b for a min-queue, a>b for a max-queue).
//              Equal keys never beat each other, which keeps ties in arrival order.
module key_cmp
  import quickq_pkg::*;
#(
  parameter int unsigned KEY_W    = KEY_W_DEF,
  parameter int unsigned MAX_MODE = MODE_MIN
) (
  input  logic [KEY_W-1:0] a,
  input  logic [KEY_W-1:0] b,
  output logic             a_better
);

  assign a_better = (MAX_MODE == MODE_MAX) ? (a > b) : (a < b);

endmodule

// File: rtl/quick_node_pq.sv
// quick_node_pq: one node of the QuickQ systolic priority queue.
// Holds a single key; inserts ripple right as a compare-and-forward wavefront and
// pops shift the array left one node per cycle. Node 0's left side is the user port.
//   clk, reset_i / reset_o     : clock, sync active-high reset and its one-cycle copy for the
//                                right neighbour
//   write_i, read_i, data_lt_i : left request (insert / pop / both = replace) and its key
//   ready_o                    : this node accepts an op this cycle
//   data_lt_o, valid_lt_o      : held key and its valid flag
//   write_o, read_o, data_rt_o : request and key forwarded to the right node
//   data_rt_i, valid_rt_i, ready_rt_i : right node's held key, valid and ready
//   underflow_o, overflow_o    : pulses for pop of an empty node / key dropped at the tail
module quick_node_pq
  import quickq_pkg::*;
#(
  parameter int unsigned KEY_W    = KEY_W_DEF,
  parameter int unsigned MAX_MODE = MODE_MIN,
  parameter int unsigned LAST     = 0
) (
  input  logic             clk,
  input  logic             reset_i,
  output logic             reset_o,
  input  logic             write_i,
  input  logic             read_i,
  input  logic [KEY_W-1:0] data_lt_i,
  output logic             ready_o,
  output logic [KEY_W-1:0] data_lt_o,
  output logic             valid_lt_o,
  output logic             write_o,
  output logic             read_o,
  output logic [KEY_W-1:0] data_rt_o,
  input  logic [KEY_W-1:0] data_rt_i,
  input  logic             valid_rt_i,
  input  logic             ready_rt_i,
  output logic             underflow_o,
  output logic             overflow_o
);

  localparam bit IsLast = (LAST != 0);

  // The tail sees an always-empty, always-ready right neighbour.
  logic             rt_valid;
  logic             rt_ready;
  logic [KEY_W-1:0] rt_data;

  assign rt_valid = IsLast ? 1'b0 : valid_rt_i;
  assign rt_ready = IsLast ? 1'b1 : ready_rt_i;
  assign rt_data  = IsLast ? '0   : data_rt_i;

  node_state_e      state;
  logic [KEY_W-1:0] held;
  logic             held_v;

  assign data_lt_o  = held;
  assign valid_lt_o = held_v;
  assign ready_o    = (state == IDLE) && rt_ready;

  logic key_better;
  logic rt_better;

  key_cmp #(
    .KEY_W   (KEY_W),
    .MAX_MODE(MAX_MODE)
  ) u_key_vs_held (
    .a       (data_lt_i),
    .b       (held),
    .a_better(key_better)
  );

  key_cmp #(
    .KEY_W   (KEY_W),
    .MAX_MODE(MAX_MODE)
  ) u_rt_vs_key (
    .a       (rt_data),
    .b       (data_lt_i),
    .a_better(rt_better)
  );

  op_e op;
  assign op = decode_op(write_i, read_i);

  always_ff @(posedge clk) begin
    reset_o <= reset_i;
    if (reset_i) begin
      state       <= IDLE;
      held        <= '0;
      held_v      <= 1'b0;
      write_o     <= 1'b0;
      read_o      <= 1'b0;
      data_rt_o   <= '0;
      underflow_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      write_o     <= 1'b0;
      read_o      <= 1'b0;
      underflow_o <= 1'b0;
      overflow_o  <= 1'b0;
      unique case (state)
        // One dead cycle after forwarding lets the right node finish its update
        // before data_rt_i / valid_rt_i are sampled again.
        WAIT: state <= IDLE;
        IDLE: begin
          if (ready_o) begin
            unique case (op)
              OP_INSERT: begin
                if (!held_v) begin
                  held   <= data_lt_i;
                  held_v <= 1'b1;
                end else begin
                  if (key_better) begin
                    held      <= data_lt_i;
                    data_rt_o <= held;
                  end else begin
                    data_rt_o <= data_lt_i;
                  end
                  // At the tail the loser has nowhere to go.
                  write_o    <= !IsLast;
                  overflow_o <= IsLast;
                  if (!IsLast) state <= WAIT;
                end
              end
              OP_POP: begin
                if (held_v) begin
                  held   <= rt_data;
                  held_v <= rt_valid;
                  read_o <= rt_valid;
                  if (rt_valid) state <= WAIT;
                end else begin
                  underflow_o <= 1'b1;
                end
              end
              OP_REPLACE: begin
                if (held_v && rt_valid && rt_better) begin
                  held      <= rt_data;
                  read_o    <= 1'b1;
                  write_o   <= 1'b1;
                  data_rt_o <= data_lt_i;
                  state     <= WAIT;
                end else begin
                  held        <= data_lt_i;
                  held_v      <= 1'b1;
                  underflow_o <= !held_v;
                end
              end
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/quick_node_pq.md
Name: quick_node_pq

Overview:
- Parametrised systolic priority-queue node for the QuickQ array; the successor to the single-bit quick node.
- Holds one KEY_W-bit key with a valid flag. Inserts ripple rightward as a compare-and-forward wavefront; pops shift the array left one node per cycle.
- Adds MIN/MAX mode, a combined replace operation, ready/backpressure, and underflow/overflow reporting.
- N instances chain left-to-right. Node 0's left side is the queue user port.

Parameters:
- KEY_W, 16: key width in bits.
- MAX_MODE, 0: 0 means the smallest key is best (min-queue); 1 means the largest key is best (max-queue).
- LAST, 0: 1 marks the tail node. Right-side inputs are ignored and treated as valid_rt_i=0, ready_rt_i=1.

Ports:
- clk  in  1  clock.
- reset_i  in  1  reset.
- reset_o  out  1  reset_i registered one cycle, fed to the right node.
- write_i  in  1  insert request from the left.
- read_i  in  1  pop request from the left.
- data_lt_i  in  KEY_W  key to insert.
- ready_o  out  1  node accepts an op this cycle.
- data_lt_o  out  KEY_W  held key (registered).
- valid_lt_o  out  1  held key is valid.
- write_o  out  1  insert request to the right node.
- read_o  out  1  pop request to the right node.
- data_rt_o  out  KEY_W  key forwarded to the right node.
- data_rt_i  in  KEY_W  right node's held key.
- valid_rt_i  in  1  right node's held key is valid.
- ready_rt_i  in  1  right node's ready_o.
- underflow_o  out  1  one-cycle pulse: pop issued to an empty node.
- overflow_o  out  1  one-cycle pulse: LAST node dropped a key.

Behaviour:
- Reset: one clock, reset synchronous, active-high; reset_i high clears all state synchronously.
  - On reset, held_v=0, held=0, write_o=read_o=0, data_rt_o=0, underflow_o=overflow_o=0, state=IDLE.
  - reset_i overrides any op in the same cycle; the op is discarded.
  - reset_o <= reset_i every cycle, so array reset completes in N cycles.
- better(a,b): a<b when MAX_MODE=0, a>b when MAX_MODE=1. Equal keys are never "better", so the resident key stays and the newcomer goes right (FIFO among ties).
- ready_o = (state==IDLE) && ready_rt_i.
  - Ops with ready_o low are ignored; the left side must hold the request until ready_o is high.
  - Ignored ops raise no flags.
- States:
  - IDLE → WAIT when the op accepted at cycle t asserts write_o or read_o at t+1.
  - WAIT → IDLE unconditionally after one cycle.
  - Consequence: propagating ops have an issue interval of 2, and ready_o is low at t+1. This guarantees data_rt_i/valid_rt_i reflect the right node's completed update before they are next sampled.
- Insert (write_i only, accepted at t):
  - If !held_v: held<=key, held_v<=1. No forward; stay IDLE.
  - Else, let win = better(key,held) ? key : held, and lose = the other. Then held<=win and data_rt_o<=lose.
    - If !LAST: write_o<=1 at t+1.
    - If LAST: lose is dropped and overflow_o=1 at t+1.
- Pop (read_i only, accepted at t):
  - The left side samples data_lt_o at t.
  - If held_v: held<=data_rt_i, held_v<=valid_rt_i, read_o<=valid_rt_i at t+1.
  - If !held_v: underflow_o=1 at t+1; no state change.
- Replace (read_i & write_i, accepted at t):
  - The left side samples the old held at t.
  - If held_v && valid_rt_i && better(data_rt_i,key): held<=data_rt_i, and both read_o=1 and write_o=1 at t+1 with data_rt_o=key. The right node then performs a replace.
  - Otherwise: held<=key, held_v<=1, no propagation. underflow_o pulses at t+1 iff held_v was 0.
- Output registers:
  - write_o/read_o/underflow_o/overflow_o are single-cycle pulses.
  - data_rt_o holds its value until the next forward.

Decomposition:
- quickq_pkg:
  - node_state_e {IDLE, WAIT}
  - default width constant KEY_W_DEF=16
  - MODE_MIN/MODE_MAX localparams
- Sub-module key_cmp:
  - Parameters KEY_W, MAX_MODE.
  - Inputs a, b; output a_better.
  - Purely combinational, strict compare.
  - Two instances: key vs held, and data_rt_i vs key.

Test Plan:
- Reset, then insert 5 into an empty node (KEY_W=8, min) → next cycle data_lt_o=5, valid_lt_o=1, write_o=0, ready_o=1.
- Node holds 5; insert 3 at t → t+1: held 3, write_o=1, data_rt_o=5, ready_o=0; t+2: ready_o=1. Same with held 5 and insert 5 → held 5, data_rt_o=5 forwarded.
- 4-node chain (last LAST=1); insert 7,2,9,4 two cycles apart → settles to 2,4,7,9. Then pops return 2,4,7,9 in order; a 5th pop gives underflow_o=1 at node 0. Repeat with MAX_MODE=1 → pops return 9,7,4,2.
- Tail node holds 9, insert 8 → held 8, overflow_o=1 for exactly one cycle, write_o=0.
- Node holds 2, right holds 4; replace with key 5 → left samples 2; next cycle held 4, read_o=1, write_o=1, data_rt_o=5.
- write_i=1 and reset_i=1 in the same cycle on a valid node → t+1: valid_lt_o=0, write_o=0, reset_o=1, overflow_o=0.
